// File: rtl/echo_fifo_app.sv
// USB-CDC echo stage: OUT bytes return on IN through a DEPTH-entry FIFO, with LF inserted after CR.
// Optional build macro UPPERCASE_EN folds 'a'..'z' to upper case at push time.
module echo_fifo_app #(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter int unsigned IDLE_CYCLES = 2000000
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [7:0] out_data_i,
  input  logic       out_valid_i,
  output logic       out_ready_o,
  output logic [7:0] in_data_o,
  output logic       in_valid_o,
  input  logic       in_ready_i,
  output logic       sleep_o
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W  = DEPTH_LOG2;
  localparam int unsigned CNT_W  = DEPTH_LOG2 + 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [7:0]  CR     = 8'h0D;
  localparam logic [7:0]  LF     = 8'h0A;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_LF_PEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic                sleep_q, sleep_d;
  logic [7:0]          mem_q [DEPTH];

  logic                full_c;
  logic                pop_c;
  logic                push_c;
  logic [7:0]          push_data_c;
  logic                out_ready_c;
  logic                out_xfer_c;

  function automatic logic [7:0] fold_case(input logic [7:0] b);
    logic [7:0] r;
    r = b;
`ifdef UPPERCASE_EN
    if ((b >= 8'h61) && (b <= 8'h7A)) r[5] = 1'b0;
`else
`endif
    return r;
  endfunction

  assign full_c     = (count_q == CNT_W'(DEPTH));
  assign in_valid_o = (count_q != '0);
  assign pop_c      = in_valid_o && in_ready_i;
  assign out_xfer_c = out_valid_i && out_ready_c;

  // Head entry only changes on a pop, so data is stable while stalled.
  assign in_data_o   = in_valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign out_ready_o = out_ready_c && rstn_i;
  assign sleep_o     = sleep_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= ST_ACCEPT;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCEPT: begin
        if (out_xfer_c && (out_data_i == CR)) state_d = ST_LF_PEND;
      end
      ST_LF_PEND: begin
        if (!full_c || pop_c) state_d = ST_ACCEPT;
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  // FSM outputs; a pop in the same cycle frees the slot for a pending LF
  always_comb begin
    out_ready_c = 1'b0;
    push_c      = 1'b0;
    push_data_c = 8'h00;
    case (state_q)
      ST_ACCEPT: begin
        out_ready_c = !full_c;
        push_c      = out_valid_i && !full_c;
        push_data_c = fold_case(out_data_i);
      end
      ST_LF_PEND: begin
        push_c      = !full_c || pop_c;
        push_data_c = LF;
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping and idle timer
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    idle_d   = idle_q;
    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (out_xfer_c || pop_c || (count_q != '0)) idle_d = '0;
    else if (idle_q != IDLE_W'(IDLE_CYCLES))    idle_d = idle_q + IDLE_W'(1);
    sleep_d = (idle_d == IDLE_W'(IDLE_CYCLES));
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idle_q   <= '0;
      sleep_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idle_q   <= idle_d;
      sleep_q  <= sleep_d;
    end
  end

  // Storage is not reset; pointers and count define validity
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= push_data_c;
  end

endmodule

// File: tb/tb_echo_fifo_app.sv
// Bench for echo_fifo_app: transaction-level model (expected byte queue, occupancy, pending LF, idle time).
module tb_echo_fifo_app;

  localparam int unsigned DEPTH_LOG2 = 4;
  localparam int DEPTH = 16;
  localparam int IDLE  = 20;

  logic       clk = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] out_data_i = 8'h00;
  logic       out_valid_i = 1'b0;
  logic       out_ready_o;
  logic [7:0] in_data_o;
  logic       in_valid_o;
  logic       in_ready_i = 1'b0;
  logic       sleep_o;

  echo_fifo_app #(.DEPTH_LOG2(DEPTH_LOG2), .IDLE_CYCLES(IDLE)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .out_data_i  (out_data_i),
    .out_valid_i (out_valid_i),
    .out_ready_o (out_ready_o),
    .in_data_o   (in_data_o),
    .in_valid_o  (in_valid_o),
    .in_ready_i  (in_ready_i),
    .sleep_o     (sleep_o)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int  occ     = 0;
  bit  lf_pend = 0;
  int  idle    = 0;
  bit  stall_v = 0;
  logic [7:0] stall_d = 8'h00;

  function automatic logic [7:0] ref_fold(input logic [7:0] b);
`ifdef UPPERCASE_EN
    if (b inside {[8'h61:8'h7A]}) return b - 8'h20;
`else
`endif
    return b;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs and inputs are stable at the falling edge; evaluate the upcoming edge.
  always @(negedge clk) begin
    bit pop, acc, lf_now;
    logic [7:0] e;
    if (!rstn_i) begin
      occ = 0; lf_pend = 0; idle = 0; stall_v = 0;
      exp_q.delete();
    end else begin
      chk("in_valid", 8'(in_valid_o), 8'(occ != 0));
      chk("out_ready", 8'(out_ready_o), 8'(!lf_pend && occ < DEPTH));
      chk("sleep", 8'(sleep_o), 8'(idle == IDLE));
      if (stall_v && in_valid_o) chk("in_hold", in_data_o, stall_d);
      pop = in_valid_o && in_ready_i;
      acc = out_valid_i && out_ready_o;
      if (pop) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL in_data: got %02h expected none (queue empty) at %0t", in_data_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("in_data", in_data_o, e);
        end
      end
      if (acc) begin
        exp_q.push_back(ref_fold(out_data_i));
        if (out_data_i == 8'h0D) exp_q.push_back(8'h0A);
      end
      if (acc || pop || occ != 0) idle = 0;
      else if (idle < IDLE) idle++;
      lf_now  = lf_pend && (occ < DEPTH || pop);
      occ     = occ - int'(pop) + int'(lf_now) + int'(acc);
      lf_pend = (lf_pend && !lf_now) || (acc && out_data_i == 8'h0D);
      stall_v = in_valid_o && !in_ready_i;
      stall_d = in_data_o;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    bit acc;
    int guard;
    out_valid_i = 1'b1;
    out_data_i  = b;
    guard = 0;
    acc = 0;
    while (!acc && guard < 300) begin
      @(negedge clk);
      acc = out_ready_o;
      tick();
      guard++;
    end
    if (!acc) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: byte %02h not accepted after %0d cycles", b, guard);
    end
    out_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    in_ready_i = 1'b1;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!in_valid_o && exp_q.size() == 0 && !lf_pend) done = 1;
      tick();
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: in_valid %0b, %0d bytes still expected", in_valid_o, exp_q.size());
    end
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    out_valid_i = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_out_ready", 8'(out_ready_o), 8'h00);
    chk("rst_in_valid", 8'(in_valid_o), 8'h00);
    chk("rst_in_data", in_data_o, 8'h00);
    chk("rst_sleep", 8'(sleep_o), 8'h00);
    tick();
    rstn_i = 1'b1;
  endtask

  function automatic logic [7:0] rnd_byte();
    case ($urandom_range(3))
      0:       return 8'h0D;
      1:       return 8'(8'h61 + $urandom_range(25));
      default: return 8'($urandom_range(255));
    endcase
  endfunction

  initial begin
    bit hold;
    do_reset();

    // Single byte round trip, then idle into sleep
    in_ready_i = 1'b1;
    send(8'h41);
    drain();
    repeat (IDLE + 5) tick();
    @(negedge clk);
    chk("sleep_after_idle", 8'(sleep_o), 8'h01);
    tick();
    send(8'h42);
    drain();
    repeat (IDLE + 3) tick();

    // Fill to full with the consumer stalled; 17th byte is held off
    in_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h30 + i));
    out_valid_i = 1'b1;
    out_data_i  = 8'h40;
    repeat (3) tick();
    @(negedge clk);
    chk("full_block", 8'(out_ready_o), 8'h00);
    tick();
    in_ready_i = 1'b1;
    send(8'h40);
    drain();

    // CR followed by LF insertion, back to back
    send(8'h48);
    send(8'h0D);
    send(8'h49);
    drain();

    // Pending LF while full, released by a single pop
    in_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) send(8'(8'h50 + i));
    send(8'h0D);
    repeat (3) tick();
    in_ready_i = 1'b1;
    tick();
    in_ready_i = 1'b0;
    repeat (2) tick();
    drain();

    // Case folding patterns
    send(8'h61);
    send(8'h7A);
    send(8'h7B);
    send(8'h5A);
    send(8'h60);
    drain();

    // Randomized traffic with bursty back-pressure
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      hold = out_valid_i && !out_ready_o;
      tick();
      if (!hold) begin
        out_valid_i = ($urandom_range(9) < 6);
        out_data_i  = rnd_byte();
      end
      if ((i % 300) < 150) in_ready_i = 1'($urandom_range(1));
      else                 in_ready_i = ($urandom_range(3) == 0);
      if ((i % 500) == 499) begin
        out_valid_i = 1'b0;
        hold = 0;
        in_ready_i = 1'b1;
        repeat (IDLE + 8) tick();
      end
    end
    out_valid_i = 1'b0;
    drain();

    // Reset while full with an LF pending discards everything
    in_ready_i = 1'b0;
    for (int i = 0; i < 15; i++) send(8'(8'h70 + i));
    send(8'h0D);
    repeat (2) tick();
    do_reset();
    @(negedge clk);
    chk("post_rst_empty", 8'(in_valid_o), 8'h00);
    tick();
    in_ready_i = 1'b1;
    send(8'h55);
    send(8'h0D);
    drain();
    repeat (IDLE + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
